inst_cache_refill_ctrl: RTL and testbench

INST_CACHE_REFILL_CTRL -- requirements
Module: inst_cache_refill_ctrl

---
 rtl/inst_cache_refill_ctrl.sv | 111 +++++++++++
 tb/tb_inst_cache_refill_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/inst_cache_refill_ctrl.sv
// inst_cache_refill_ctrl: direct-mapped I-cache controller owning valid/tag state and refilling whole lines by memory burst.
module inst_cache_refill_ctrl #(
  parameter int LINE_WORDS = 8,
  parameter int LINE_NUM   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_req,
  input  logic [31:0] fetch_addr,
  output logic        fetch_ready,
  output logic        fetch_valid,
  output logic [31:0] fetch_data,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        cache_write_en,
  output logic [31:0] cache_write_addr,
  output logic [31:0] cache_write_data,
  output logic        cache_read_en,
  output logic [31:0] cache_read_addr,
  input  logic [31:0] cache_read_data
);
  localparam int CW = $clog2(LINE_WORDS);
  localparam int OW = CW + 2;
  localparam int IW = $clog2(LINE_NUM);
  localparam int TW = 32 - OW - IW;
  localparam logic [1:0] IDLE = 2'd0, MREQ = 2'd1, FILL = 2'd2, RESP = 2'd3;
  logic [1:0] state_q, state_d;
  logic [31:0] addr_q, addr_d, fetch_data_q, fetch_data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [LINE_NUM-1:0] valid_q, valid_d;
  logic [TW-1:0] tag_q [LINE_NUM];
  logic flush_pend_q, flush_pend_d, fetch_valid_q, fetch_valid_d;
  logic [IW-1:0] req_idx, line_idx;
  logic accept, hit, last_beat;
  assign req_idx = fetch_addr[OW +: IW];
  assign line_idx = addr_q[OW +: IW];
  assign fetch_ready = state_q == IDLE && !flush;
  assign accept = fetch_req && fetch_ready;
  assign hit = valid_q[req_idx] && tag_q[req_idx] == fetch_addr[31 -: TW];
  assign cache_read_en = (accept && hit) || state_q == RESP;
  assign cache_read_addr = state_q == RESP ? addr_q : (accept && hit) ? fetch_addr : '0;
  assign cache_write_en = state_q == FILL && mem_rvalid;
  assign cache_write_addr = cache_write_en ? {addr_q[31:OW], cnt_q, 2'b00} : '0;
  assign cache_write_data = cache_write_en ? mem_rdata : '0;
  assign mem_req = state_q == MREQ;
  assign mem_addr = mem_req ? {addr_q[31:OW], {OW{1'b0}}} : '0;
  assign last_beat = cache_write_en && cnt_q == CW'(LINE_WORDS - 1);
  assign fetch_valid = fetch_valid_q;
  assign fetch_data = fetch_data_q;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    valid_d = valid_q;
    flush_pend_d = flush_pend_q || (flush && state_q != IDLE);
    fetch_valid_d = 1'b0;
    fetch_data_d = fetch_data_q;
    if (state_q == IDLE && flush) valid_d = '0;
    if (accept) begin
      addr_d = fetch_addr;
      if (hit) begin
        fetch_valid_d = 1'b1;
        fetch_data_d = cache_read_data;
      end else begin
        valid_d[req_idx] = 1'b0;
        state_d = MREQ;
      end
    end
    if (state_q == MREQ && mem_ack) begin
      cnt_d = '0;
      state_d = FILL;
    end
    if (cache_write_en) cnt_d = cnt_q + 1'b1;
    if (last_beat) begin
      valid_d[line_idx] = 1'b1;
      state_d = RESP;
    end
    // a flush seen during the refill also drops the line just filled, after its response goes out
    if (state_q == RESP) begin
      fetch_valid_d = 1'b1;
      fetch_data_d = cache_read_data;
      state_d = IDLE;
      valid_d = flush_pend_d ? '0 : valid_d;
      flush_pend_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q <= '0;
      cnt_q <= '0;
      valid_q <= '0;
      flush_pend_q <= 1'b0;
      fetch_valid_q <= 1'b0;
      fetch_data_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      valid_q <= valid_d;
      flush_pend_q <= flush_pend_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_data_q <= fetch_data_d;
    end
  end
  always_ff @(posedge clk) if (last_beat) tag_q[line_idx] <= addr_q[31 -: TW];
endmodule

// File: tb/tb_inst_cache_refill_ctrl.sv
// tb_inst_cache_refill_ctrl: directed vector table, corner sequences and random fetches against a line-level cache model.
module tb_inst_cache_refill_ctrl;
  logic clk = 0, rst = 1, fetch_req = 0, flush = 0, mem_ack = 0, mem_rvalid = 0;
  logic [31:0] fetch_addr = 0, mem_rdata = 0;
  logic fetch_ready, fetch_valid, mem_req, cache_write_en, cache_read_en;
  logic [31:0] fetch_data, mem_addr, cache_write_addr, cache_write_data, cache_read_addr, cache_read_data;
  logic [31:0] cmem [128];
  bit m_valid [16];
  logic [22:0] m_tag [16];
  int pass_cnt = 0, total_cnt = 0;
  typedef struct {logic [31:0] addr; int gap; bit fl; bit hit;} vec_t;
  vec_t tbl [10];

  inst_cache_refill_ctrl dut (
    .clk(clk), .rst(rst), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
    .fetch_ready(fetch_ready), .fetch_valid(fetch_valid), .fetch_data(fetch_data),
    .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .cache_write_en(cache_write_en),
    .cache_write_addr(cache_write_addr), .cache_write_data(cache_write_data),
    .cache_read_en(cache_read_en), .cache_read_addr(cache_read_addr),
    .cache_read_data(cache_read_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) if (cache_write_en) cmem[cache_write_addr[8:2]] <= cache_write_data;
  assign cache_read_data = cmem[cache_read_addr[8:2]];

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return ({a[31:2], 2'b00} * 32'h0001_0003) ^ 32'h5A5A_1234;
  endfunction

  function automatic bit pred_hit(input logic [31:0] a);
    return m_valid[a[8:5]] && m_tag[a[8:5]] == a[31:9];
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 0;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  task automatic chk_reset_outs();
    chk("rst_fetch_valid", fetch_valid, 0);
    chk("rst_fetch_data", fetch_data, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_wr_en", cache_write_en, 0);
    chk("rst_wr_addr", cache_write_addr, 0);
    chk("rst_wr_data", cache_write_data, 0);
    chk("rst_rd_en", cache_read_en, 0);
    chk("rst_rd_addr", cache_read_addr, 0);
  endtask

  task automatic do_fetch(input logic [31:0] a, input int gap, input bit fl, input bit exp_hit, input int abort);
    logic [31:0] base;
    int w, k, cyc;
    base = {a[31:5], 5'b0};
    w = 0;
    @(negedge clk);
    chk("valid_pulse_end", fetch_valid, 0);
    while (!fetch_ready && w < 20) begin @(negedge clk); w++; end
    chk("ready", fetch_ready, 1);
    fetch_req = 1; fetch_addr = a; #1;
    chk("rd_en_acc", cache_read_en, exp_hit);
    if (exp_hit) chk("rd_addr_acc", cache_read_addr, a);
    @(negedge clk); fetch_req = 0; fetch_addr = $urandom; #1;
    if (exp_hit) begin
      chk("hit_valid", fetch_valid, 1);
      chk("hit_data", fetch_data, mdata(a));
      chk("hit_no_mreq", mem_req, 0);
      return;
    end
    chk("mreq", mem_req, 1);
    chk("maddr", mem_addr, base);
    chk("busy", fetch_ready, 0);
    chk("miss_no_valid", fetch_valid, 0);
    repeat ($urandom_range(0, 2)) begin
      mem_rvalid = 1; mem_rdata = $urandom; #1;
      chk("rvalid_ignored_mreq", cache_write_en, 0);
      @(negedge clk); mem_rvalid = 0; #1;
      chk("mreq_hold", mem_req, 1);
      chk("maddr_hold", mem_addr, base);
    end
    mem_ack = 1;
    @(negedge clk); mem_ack = 0; #1;
    chk("mreq_drop", mem_req, 0);
    k = 0; cyc = 0;
    while (k < 8 && cyc < 200) begin
      if (abort >= 0 && k == abort) begin
        mem_rvalid = 0; flush = 0; mem_ack = 0;
        rst = 1; #1;
        chk_reset_outs();
        @(negedge clk); rst = 0; #1;
        chk("ready_after_rst", fetch_ready, 1);
        model_clear();
        return;
      end
      mem_rvalid = $urandom_range(0, 99) >= gap;
      mem_rdata = mem_rvalid ? mdata(base + 4 * k) : $urandom;
      mem_ack = $urandom_range(0, 1);
      flush = fl && k == 3;
      #1;
      chk("wr_en", cache_write_en, mem_rvalid);
      if (mem_rvalid) begin
        chk("wr_addr", cache_write_addr, base + 4 * k);
        chk("wr_data", cache_write_data, mdata(base + 4 * k));
      end
      chk("rd_wr_excl", cache_read_en, 0);
      if (mem_rvalid) k++;
      @(negedge clk); cyc++;
    end
    mem_rvalid = 0; mem_ack = 0; flush = 0; #1;
    chk("resp_rd_en", cache_read_en, 1);
    chk("resp_rd_addr", cache_read_addr, a);
    chk("resp_wr_en", cache_write_en, 0);
    chk("resp_no_valid", fetch_valid, 0);
    @(negedge clk); #1;
    chk("miss_valid", fetch_valid, 1);
    chk("miss_data", fetch_data, mdata(a));
    m_valid[a[8:5]] = 1;
    m_tag[a[8:5]] = a[31:9];
    if (fl) model_clear();
  endtask

  initial begin
    logic [31:0] a;
    for (int i = 0; i < 128; i++) cmem[i] = 0;
    model_clear();
    tbl[0] = '{32'h0000_1234, 0, 0, 0};
    tbl[1] = '{32'h0000_1238, 0, 0, 1};
    tbl[2] = '{32'h0000_1420, 0, 0, 0};
    tbl[3] = '{32'h0000_1220, 0, 0, 0};
    tbl[4] = '{32'h0000_1224, 0, 0, 1};
    tbl[5] = '{32'h0000_1240, 50, 0, 0};
    tbl[6] = '{32'h0000_2000, 30, 1, 0};
    tbl[7] = '{32'h0000_1220, 0, 0, 0};
    tbl[8] = '{32'h0000_2004, 0, 0, 0};
    tbl[9] = '{32'h0000_1228, 0, 0, 1};
    repeat (2) @(negedge clk);
    #1 chk_reset_outs();
    @(negedge clk); rst = 0; #1;
    chk("ready_initial", fetch_ready, 1);
    for (int i = 0; i < 10; i++) do_fetch(tbl[i].addr, tbl[i].gap, tbl[i].fl, tbl[i].hit, -1);
    // back-to-back hits on consecutive cycles
    @(negedge clk); fetch_req = 1; fetch_addr = 32'h0000_1224; #1;
    chk("b2b_rd_en0", cache_read_en, 1);
    @(negedge clk); fetch_addr = 32'h0000_2008; #1;
    chk("b2b_ready", fetch_ready, 1);
    chk("b2b_rd_en1", cache_read_en, 1);
    chk("b2b_valid0", fetch_valid, 1);
    chk("b2b_data0", fetch_data, mdata(32'h0000_1224));
    @(negedge clk); fetch_req = 0; #1;
    chk("b2b_valid1", fetch_valid, 1);
    chk("b2b_data1", fetch_data, mdata(32'h0000_2008));
    // flush coincident with a request in IDLE
    @(negedge clk); flush = 1; fetch_req = 1; fetch_addr = 32'h0000_1220; #1;
    chk("flush_ready", fetch_ready, 0);
    chk("flush_rd_en", cache_read_en, 0);
    @(negedge clk); flush = 0; fetch_req = 0; #1;
    chk("flush_no_valid", fetch_valid, 0);
    chk("flush_no_mreq", mem_req, 0);
    model_clear();
    do_fetch(32'h0000_1220, 0, 0, 0, -1);
    do_fetch(32'h0000_3000, 20, 0, 0, 3);
    do_fetch(32'h0000_3000, 0, 0, 0, -1);
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        @(negedge clk); flush = 1; #1;
        chk("idle_flush_ready", fetch_ready, 0);
        @(negedge clk); flush = 0;
        model_clear();
      end
      a = ($urandom_range(0, 2) << 9) | ($urandom_range(0, 15) << 5) | $urandom_range(0, 31);
      do_fetch(a, $urandom_range(0, 40), $urandom_range(0, 7) == 0, pred_hit(a), -1);
    end
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
